// File: rtl/legv8_multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : legv8_multicycle_control_if
//  Brief    : Opcode in, datapath controls and status out, for the LEGv8
//             multi-cycle controller.
//  Revision : 1.0
// ============================================================================
interface legv8_multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [10:0]      opcode;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_source;
    logic             ir_write;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             reg2loc;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [2:0]       state;
    logic             illegal;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode,
        output pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
               mem_write, mem_to_reg, reg_write, reg2loc, alu_src_a, alu_src_b,
               alu_op, state, illegal, instr_done, instr_count
    );

    modport slave (
        output opcode,
        input  pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
               mem_write, mem_to_reg, reg_write, reg2loc, alu_src_a, alu_src_b,
               alu_op, state, illegal, instr_done, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/legv8_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : legv8_multicycle_control
//  Brief    : Moore FSM sequencing LEGv8 instructions through
//             FETCH/DECODE/EXEC/MEM/WB with configurable memory wait.
//  Revision : 1.0
// ============================================================================
module legv8_multicycle_control #(
    parameter int MEM_WAIT     = 0,
    parameter int SUPPORT_B    = 1,
    parameter int ILLEGAL_HALT = 1,
    parameter int CNT_W        = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    legv8_multicycle_control_if.master        bus
);
    localparam int c_wait_w = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MEM_WAIT);

    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_halt   = 3'd7;

    localparam logic [2:0] c_cl_none  = 3'd0;
    localparam logic [2:0] c_cl_rtype = 3'd1;
    localparam logic [2:0] c_cl_ldur  = 3'd2;
    localparam logic [2:0] c_cl_stur  = 3'd3;
    localparam logic [2:0] c_cl_cbz   = 3'd4;
    localparam logic [2:0] c_cl_b     = 3'd5;
    localparam logic [2:0] c_cl_ill   = 3'd6;

    logic [2:0]          r_state;
    logic [2:0]          r_class;
    logic [c_wait_w-1:0] r_wait;
    logic                r_illegal;
    logic [CNT_W-1:0]    r_count;

    logic [2:0] w_next;
    logic [2:0] w_dec_class;
    logic       w_last;
    logic       w_pc_write, w_pc_write_cond, w_ir_write, w_i_or_d, w_mem_read;
    logic       w_mem_write, w_mem_to_reg, w_reg_write, w_reg2loc, w_alu_src_a;
    logic       w_done;
    logic [1:0] w_pc_source, w_alu_src_b, w_alu_op;

    assign w_last = (r_wait == c_wait_last);

    // Priority order matters: LDUR/STUR/CBZ must not be shadowed by broader matches.
    always_comb begin
        w_dec_class = c_cl_ill;
        if (bus.opcode[10] && bus.opcode[7:4] == 4'b0101 && bus.opcode[2:0] == 3'b000)
            w_dec_class = c_cl_rtype;
        else if (bus.opcode == 11'b11111000010)
            w_dec_class = c_cl_ldur;
        else if (bus.opcode == 11'b11111000000)
            w_dec_class = c_cl_stur;
        else if (bus.opcode[10:3] == 8'b10110100)
            w_dec_class = c_cl_cbz;
        else if ((SUPPORT_B != 0) && bus.opcode[10:5] == 6'b000101)
            w_dec_class = c_cl_b;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_fetch:  if (w_last) w_next = c_st_decode;
            c_st_decode: begin
                if (w_dec_class == c_cl_ill)
                    w_next = (ILLEGAL_HALT != 0) ? c_st_halt : c_st_fetch;
                else
                    w_next = c_st_exec;
            end
            c_st_exec: begin
                case (r_class)
                    c_cl_rtype:           w_next = c_st_wb;
                    c_cl_ldur, c_cl_stur: w_next = c_st_mem;
                    default:              w_next = c_st_fetch;
                endcase
            end
            c_st_mem:  if (w_last) w_next = (r_class == c_cl_ldur) ? c_st_wb : c_st_fetch;
            c_st_wb:   w_next = c_st_fetch;
            c_st_halt: w_next = c_st_halt;
            default:   w_next = c_st_fetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_fetch;
            r_wait    <= '0;
            r_class   <= c_cl_none;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            // Counter runs only within an access and is zero whenever one begins.
            if ((r_state == c_st_fetch || r_state == c_st_mem) && !w_last)
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;
            if (r_state == c_st_decode) begin
                r_class <= w_dec_class;
                if (w_dec_class == c_cl_ill)
                    r_illegal <= 1'b1;
            end
            if (w_done)
                r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        w_pc_write = 1'b0; w_pc_write_cond = 1'b0; w_pc_source = 2'b00;
        w_ir_write = 1'b0; w_i_or_d = 1'b0; w_mem_read = 1'b0;
        w_mem_write = 1'b0; w_mem_to_reg = 1'b0; w_reg_write = 1'b0;
        w_reg2loc = 1'b0; w_alu_src_a = 1'b0; w_alu_src_b = 2'b00;
        w_alu_op = 2'b00; w_done = 1'b0;
        case (r_state)
            c_st_fetch: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (w_last) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                end
            end
            c_st_decode: w_alu_src_b = 2'b11;
            c_st_exec: begin
                case (r_class)
                    c_cl_rtype: begin
                        w_alu_src_a = 1'b1;
                        w_alu_op    = 2'b10;
                    end
                    c_cl_ldur, c_cl_stur: begin
                        w_reg2loc   = 1'b1;
                        w_alu_src_a = 1'b1;
                        w_alu_src_b = 2'b10;
                    end
                    c_cl_cbz: begin
                        w_reg2loc       = 1'b1;
                        w_alu_src_a     = 1'b1;
                        w_alu_op        = 2'b01;
                        w_pc_write_cond = 1'b1;
                        w_pc_source     = 2'b01;
                        w_done          = 1'b1;
                    end
                    c_cl_b: begin
                        w_pc_write  = 1'b1;
                        w_pc_source = 2'b01;
                        w_done      = 1'b1;
                    end
                    default: ;
                endcase
            end
            c_st_mem: begin
                w_i_or_d = 1'b1;
                if (r_class == c_cl_ldur)
                    w_mem_read = 1'b1;
                if (r_class == c_cl_stur && w_last) begin
                    w_mem_write = 1'b1;
                    w_done      = 1'b1;
                end
            end
            c_st_wb: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = (r_class == c_cl_ldur);
                w_done       = 1'b1;
            end
            default: ;
        endcase
        // Reset suppresses every strobe so an aborted instruction has no side effect.
        if (rst) begin
            w_pc_write = 1'b0; w_pc_write_cond = 1'b0; w_pc_source = 2'b00;
            w_ir_write = 1'b0; w_i_or_d = 1'b0; w_mem_read = 1'b0;
            w_mem_write = 1'b0; w_mem_to_reg = 1'b0; w_reg_write = 1'b0;
            w_reg2loc = 1'b0; w_alu_src_a = 1'b0; w_alu_src_b = 2'b00;
            w_alu_op = 2'b00; w_done = 1'b0;
        end
    end

    assign bus.pc_write      = w_pc_write;
    assign bus.pc_write_cond = w_pc_write_cond;
    assign bus.pc_source     = w_pc_source;
    assign bus.ir_write      = w_ir_write;
    assign bus.i_or_d        = w_i_or_d;
    assign bus.mem_read      = w_mem_read;
    assign bus.mem_write     = w_mem_write;
    assign bus.mem_to_reg    = w_mem_to_reg;
    assign bus.reg_write     = w_reg_write;
    assign bus.reg2loc       = w_reg2loc;
    assign bus.alu_src_a     = w_alu_src_a;
    assign bus.alu_src_b     = w_alu_src_b;
    assign bus.alu_op        = w_alu_op;
    assign bus.instr_done    = w_done;
    assign bus.state         = r_state;
    assign bus.illegal       = r_illegal;
    assign bus.instr_count   = r_count;
endmodule
`default_nettype wire
